// File: rtl/mux16_rr_scheduler_pkg.sv
// rtl/mux16_rr_scheduler_pkg.sv - shared constants, state encoding and round-robin pick
package mux16_rr_scheduler_pkg;

    localparam int N     = 16;
    localparam int SEL_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEL  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    // Rotate so the pointer sits at bit 0, take the lowest set bit, then rotate back.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [N-1:0] eff,
                                                 input logic [SEL_W-1:0] ptr);
        logic [2*N-1:0] dbl;
        logic [SEL_W-1:0] off;
        logic found;
        dbl   = {eff, eff} >> ptr;
        off   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && dbl[i]) begin
                off   = SEL_W'(i);
                found = 1'b1;
            end
        end
        return ptr + off;
    endfunction

endpackage

// File: rtl/mux16_rr_scheduler_if.sv
// rtl/mux16_rr_scheduler_if.sv - requester/consumer bundle for the round-robin mux scheduler
interface mux16_rr_scheduler_if;
    import mux16_rr_scheduler_pkg::*;

    logic [N-1:0]     req;
    logic [N-1:0]     req_mask;
    logic [N-1:0]     in;
    logic             out_ready;
    logic             out_valid;
    logic             out_data;
    logic [SEL_W-1:0] out_sel;
    logic [N-1:0]     ack;
    logic             busy;

    modport master (
        output req, req_mask, in, out_ready,
        input  out_valid, out_data, out_sel, ack, busy
    );

    modport slave (
        input  req, req_mask, in, out_ready,
        output out_valid, out_data, out_sel, ack, busy
    );

endinterface

// File: rtl/mux16_rr_scheduler_mux.sv
// rtl/mux16_rr_scheduler_mux.sv - 16-to-1 single-bit data multiplexer
module Mux_16_to_1 (
    input  logic [15:0] data_i,
    input  logic [3:0]  sel_i,
    output logic        y_o
);

    assign y_o = data_i[sel_i];

endmodule

// File: rtl/mux16_rr_scheduler.sv
// rtl/mux16_rr_scheduler.sv - round-robin arbiter sharing one 16:1 mux, registered bit out on valid/ready
module mux16_rr_scheduler
    import mux16_rr_scheduler_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    mux16_rr_scheduler_if.slave  bus
);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [SEL_W-1:0] out_sel_q, out_sel_d;
    logic             out_valid_q, out_valid_d;
    logic             out_data_q, out_data_d;
    logic [N-1:0]     ack_q, ack_d;
    logic [N-1:0]     eff_req;
    logic             mux_bit;

    assign eff_req = bus.req & bus.req_mask;

    Mux_16_to_1 u_mux (
        .data_i (bus.in),
        .sel_i  (out_sel_q),
        .y_o    (mux_bit)
    );

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        ack_d       = '0;
        case (state_q)
            ST_IDLE: begin
                if (eff_req != '0) begin
                    out_sel_d = rr_pick(eff_req, rr_ptr_q);
                    state_d   = ST_SEL;
                end
            end
            ST_SEL: begin
                out_data_d  = mux_bit;
                out_valid_d = 1'b1;
                state_d     = ST_HOLD;
            end
            ST_HOLD: begin
                if (bus.out_ready) begin
                    ack_d[out_sel_q] = 1'b1;
                    out_valid_d      = 1'b0;
                    rr_ptr_d         = out_sel_q + SEL_W'(1);
                    state_d          = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= 1'b0;
            ack_q       <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            ack_q       <= ack_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;
    assign bus.ack       = ack_q;
    assign bus.busy      = (state_q != ST_IDLE);

endmodule
